// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite ROM fetch path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//   Holds the RGB565 pixel type, the sprite geometry and key-colour defaults,
//   and the reader FSM state encoding.
package sprite_pkg;

  typedef logic [15:0] rgb565_t;

  localparam int SPR_W_DEF   = 90;
  localparam int SPR_H_DEF   = 90;
  localparam int ADDR_W_DEF  = 13;
  localparam int DATA_W_DEF  = 16;
  localparam int COORD_W_DEF = 11;

  localparam rgb565_t KEY_COLOR_DEF = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // sprite disabled for this frame
    WAIT = 2'd1,  // raster above the sprite rows
    DRAW = 2'd2,  // raster inside the sprite rows
    DONE = 2'd3   // sprite finished (or abandoned) for this frame
  } spr_state_e;

endpackage

// File: rtl/sprite_rom_reader_if.sv
// Bus bundle between raster source / ROM / mixer and the sprite ROM reader.
// Latency: n/a (wires only).
// Backpressure: none; the pixel stream and ROM are free-running.
//   slave  : the reader (consumes pixels + rom_data, drives rom_addr + output pixel)
//   master : the surrounding logic (timing generator, ROM, mixer)
interface sprite_rom_reader_if
  import sprite_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) ();

  logic               enable;
  logic               frame_start;
  logic [COORD_W-1:0] org_x;
  logic [COORD_W-1:0] org_y;
  logic               pix_valid;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic [ADDR_W-1:0]  rom_addr;
  logic [DATA_W-1:0]  rom_data;
  logic               out_valid;
  logic               out_hit;
  logic [DATA_W-1:0]  out_rgb;
  logic               seq_err;

  modport slave (
    input  enable, frame_start, org_x, org_y, pix_valid, pix_x, pix_y, rom_data,
    output rom_addr, out_valid, out_hit, out_rgb, seq_err
  );

  modport master (
    output enable, frame_start, org_x, org_y, pix_valid, pix_x, pix_y, rom_data,
    input  rom_addr, out_valid, out_hit, out_rgb, seq_err
  );

endinterface

// File: rtl/sprite_rom_reader.sv
// Sprite ROM fetch engine: maps raster pixels onto a sprite ROM and realigns the returned colour.
// Latency: 3 cycles pix_valid -> out_valid, one pixel per cycle sustained.
// Backpressure: none; every input pixel produces exactly one output pixel.
//   Ports: clk, rst_n (async active-low); bus.slave carries frame control
//   (enable/frame_start/org_x/org_y), the pixel stream (pix_*), the ROM port
//   (rom_addr/rom_data) and the mixer output (out_valid/out_hit/out_rgb/seq_err).
module sprite_rom_reader
  import sprite_pkg::*;
#(
  parameter int                SPR_W     = SPR_W_DEF,
  parameter int                SPR_H     = SPR_H_DEF,
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                COORD_W   = COORD_W_DEF,
  parameter logic [DATA_W-1:0] KEY_COLOR = DATA_W'(KEY_COLOR_DEF)
) (
  input logic              clk,
  input logic              rst_n,
  sprite_rom_reader_if.slave bus
);

  localparam logic [COORD_W:0]   SPR_W_X = (COORD_W+1)'(SPR_W);
  localparam logic [COORD_W-1:0] SPR_H_C = COORD_W'(SPR_H);
  localparam logic [ADDR_W-1:0]  SPR_W_A = ADDR_W'(SPR_W);

  spr_state_e         state_q, state_d, state_b;
  logic [COORD_W-1:0] org_x_q, org_x_d;
  logic [COORD_W-1:0] org_y_q, org_y_d;
  logic [COORD_W-1:0] cur_y_q, cur_y_d, cur_y_b;
  logic               first_q, first_d, first_b;
  logic [ADDR_W-1:0]  row_base_q, row_base_d, row_base_b;
  logic               seq_err_q, seq_err_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic               vld1_q, vld1_d, hit1_q, hit1_d;
  logic               vld2_q, vld2_d, hit2_q, hit2_d;
  logic               out_valid_q, out_valid_d;
  logic               out_hit_q, out_hit_d;
  logic [DATA_W-1:0]  out_rgb_q, out_rgb_d;

  logic               new_line;
  logic               col_hit;
  logic               in_spr0;
  logic [COORD_W-1:0] dy;

  always_comb begin
    // Frame context seen by this cycle's pixel: a frame_start takes effect
    // before the same-cycle pixel is classified.
    state_b    = state_q;
    org_x_d    = org_x_q;
    org_y_d    = org_y_q;
    cur_y_b    = cur_y_q;
    first_b    = first_q;
    row_base_b = row_base_q;
    seq_err_d  = seq_err_q;
    if (bus.frame_start) begin
      state_b    = bus.enable ? WAIT : IDLE;
      org_x_d    = bus.org_x;
      org_y_d    = bus.org_y;
      cur_y_b    = '0;
      first_b    = 1'b1;
      row_base_b = '0;
      seq_err_d  = 1'b0;
    end

    state_d    = state_b;
    cur_y_d    = cur_y_b;
    first_d    = first_b;
    row_base_d = row_base_b;

    // The first pixel of a frame always counts as a new line; otherwise a
    // sprite at org_y == 0 would never see its first row start after cur_y
    // has been cleared to 0.
    new_line = bus.pix_valid && (first_b || (bus.pix_y != cur_y_b));
    dy       = bus.pix_y - org_y_d;
    if (new_line) begin
      cur_y_d = bus.pix_y;
      first_d = 1'b0;
    end

    case (state_b)
      WAIT: begin
        if (new_line && (bus.pix_y == org_y_d)) begin
          state_d    = DRAW;
          row_base_d = '0;
        end
      end
      DRAW: begin
        if (new_line) begin
          if ((bus.pix_y == cur_y_b + COORD_W'(1)) && (dy < SPR_H_C)) begin
            row_base_d = row_base_b + SPR_W_A;
          end else if (dy == SPR_H_C) begin
            state_d = DONE;
          end else begin
            state_d   = DONE;
            seq_err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // One extra bit so org_x + SPR_W past the screen edge cannot wrap.
    col_hit = ({1'b0, bus.pix_x} >= {1'b0, org_x_d}) &&
              ({1'b0, bus.pix_x} <  ({1'b0, org_x_d} + SPR_W_X));
    in_spr0 = bus.pix_valid && (state_d == DRAW) && col_hit;

    // Hold the address on misses so the ROM input does not toggle needlessly.
    rom_addr_d = in_spr0 ? (row_base_d + ADDR_W'(bus.pix_x - org_x_d)) : rom_addr_q;

    // Valid/in-sprite travel alongside the ROM access regardless of FSM state.
    vld1_d      = bus.pix_valid;
    hit1_d      = in_spr0;
    vld2_d      = vld1_q;
    hit2_d      = hit1_q;
    out_valid_d = vld2_q;
    out_hit_d   = hit2_q && (bus.rom_data != KEY_COLOR);
    out_rgb_d   = out_hit_d ? bus.rom_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      org_x_q     <= '0;
      org_y_q     <= '0;
      cur_y_q     <= '0;
      first_q     <= 1'b0;
      row_base_q  <= '0;
      seq_err_q   <= 1'b0;
      rom_addr_q  <= '0;
      vld1_q      <= 1'b0;
      hit1_q      <= 1'b0;
      vld2_q      <= 1'b0;
      hit2_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_hit_q   <= 1'b0;
      out_rgb_q   <= '0;
    end else begin
      state_q     <= state_d;
      org_x_q     <= org_x_d;
      org_y_q     <= org_y_d;
      cur_y_q     <= cur_y_d;
      first_q     <= first_d;
      row_base_q  <= row_base_d;
      seq_err_q   <= seq_err_d;
      rom_addr_q  <= rom_addr_d;
      vld1_q      <= vld1_d;
      hit1_q      <= hit1_d;
      vld2_q      <= vld2_d;
      hit2_q      <= hit2_d;
      out_valid_q <= out_valid_d;
      out_hit_q   <= out_hit_d;
      out_rgb_q   <= out_rgb_d;
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_hit   = out_hit_q;
  assign bus.out_rgb   = out_rgb_q;
  assign bus.seq_err   = seq_err_q;

endmodule

// File: tb/tb_sprite_rom_reader.sv
// Testbench for sprite_rom_reader: behavioural ROM plus a frame-level reference model.
// Latency: expects outputs 3 cycles after each pixel, rom_addr/seq_err 1 cycle after.
// Backpressure: none; pixels are driven back to back with random blanking gaps.
module tb_sprite_rom_reader;
  import sprite_pkg::*;

  localparam int SW = 90;
  localparam int SH = 90;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sprite_rom_reader_if bus ();

  sprite_rom_reader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Synchronous-read ROM without output register.
  logic [15:0] rom [0:8191];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  typedef struct {
    bit          vld;
    bit          hit;
    logic [15:0] rgb;
  } exp_t;
  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: what a frame looks like from the sprite's point of view.
  bit          m_en, m_started, m_dead, m_seq, m_have_prev;
  int          m_ox, m_oy, m_prev_y;
  logic [12:0] m_last_addr;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, expv, $time);
    end
  endtask

  task automatic model_clear();
    m_en = 0; m_started = 0; m_dead = 0; m_seq = 0; m_have_prev = 0;
    m_ox = 0; m_oy = 0; m_prev_y = 0; m_last_addr = '0;
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      exp_t z;
      z.vld = 0; z.hit = 0; z.rgb = '0;
      exp_q.push_back(z);
    end
  endtask

  // Apply one cycle of input, predict its outcome, then check everything due now.
  task automatic step(bit fs, bit pv, int x, int y);
    exp_t e, o;
    bit   nl, in_spr;
    int   row, addr;
    bus.frame_start = fs;
    bus.pix_valid   = pv;
    bus.pix_x       = x[10:0];
    bus.pix_y       = y[10:0];
    if (fs) begin
      m_en = bus.enable; m_ox = int'(bus.org_x); m_oy = int'(bus.org_y);
      m_started = 0; m_dead = 0; m_seq = 0; m_have_prev = 0;
    end
    in_spr = 0;
    addr   = 0;
    if (pv) begin
      nl  = !m_have_prev || (y != m_prev_y);
      row = y - m_oy;
      if (nl && m_en && !m_dead) begin
        if (!m_started) begin
          if (row == 0) m_started = 1;
        end else if (!((y == m_prev_y + 1) && (row < SH))) begin
          m_dead = 1;
          if (row != SH) m_seq = 1;
        end
      end
      if (nl) begin
        m_prev_y = y; m_have_prev = 1;
      end
      in_spr = m_en && m_started && !m_dead && (x >= m_ox) && (x < m_ox + SW);
      if (in_spr) begin
        addr = row * SW + (x - m_ox);
        m_last_addr = addr[12:0];
      end
    end
    e.vld = pv;
    e.hit = in_spr && (rom[addr] != 16'h0000);
    e.rgb = e.hit ? rom[addr] : 16'h0000;
    @(posedge clk);
    #1;
    chk("rom_addr", 32'(bus.rom_addr), 32'(m_last_addr));
    chk("seq_err", 32'(bus.seq_err), 32'(m_seq));
    exp_q.push_back(e);
    if (exp_q.size() >= 3) begin
      o = exp_q.pop_front();
      chk("out_valid", 32'(bus.out_valid), 32'(o.vld));
      chk("out_hit", 32'(bus.out_hit), 32'(o.hit));
      chk("out_rgb", 32'(bus.out_rgb), 32'(o.rgb));
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic line(int y, int x0, int x1, int xs_max);
    for (int x = x0; x <= x1; x += int'($urandom_range(1, xs_max))) step(0, 1, x, y);
    idle(int'($urandom_range(0, 2)));
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_hit"}, 32'(bus.out_hit), 32'd0);
    chk({tag, "_out_rgb"}, 32'(bus.out_rgb), 32'd0);
    chk({tag, "_seq_err"}, 32'(bus.seq_err), 32'd0);
  endtask

  // Assert reset between edges so the immediate (asynchronous) clear is visible.
  task automatic mid_reset();
    #3 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    bus.pix_valid   = 1'b0;
    bus.frame_start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
  endtask

  task automatic set_org(bit en, int ox, int oy);
    bus.enable = en;
    bus.org_x  = ox[10:0];
    bus.org_y  = oy[10:0];
  endtask

  initial begin
    bus.enable = 0; bus.frame_start = 0; bus.org_x = '0; bus.org_y = '0;
    bus.pix_valid = 0; bus.pix_x = '0; bus.pix_y = '0;
    for (int i = 0; i < 8192; i++) rom[i] = 16'(i);
    rom[5] = 16'h0000;
    #1 check_reset_values("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_clear();

    // Disabled sprite: pixels pass through as misses.
    set_org(0, 100, 50);
    step(1, 0, 0, 0);
    for (int y = 48; y <= 52; y++) line(y, 95, 195, 3);

    // Full sprite at (100,50); origin inputs change mid-frame and must be ignored.
    set_org(1, 100, 50);
    step(1, 0, 0, 0);
    for (int y = 45; y <= 142; y++) begin
      if (y == 70) set_org(0, 0, 0);
      line(y, 95, 195, 1);
    end

    // Reset in the middle of drawing; no hits afterwards until a new frame.
    set_org(1, 100, 50);
    step(1, 0, 0, 0);
    for (int y = 50; y <= 52; y++) line(y, 95, 195, 2);
    for (int x = 100; x <= 140; x++) step(0, 1, x, 53);
    mid_reset();
    for (int y = 54; y <= 56; y++) line(y, 95, 195, 2);

    // Right-edge clip on a 640-wide raster, sprite starting at row 0.
    set_org(1, 600, 0);
    step(1, 0, 0, 0);
    for (int y = 0; y <= 3; y++) line(y, 560, 639, 1);

    // Row skip inside the sprite, then recovery on the next frame.
    set_org(1, 100, 50);
    step(1, 0, 0, 0);
    for (int y = 50; y <= 60; y++) line(y, 95, 195, 4);
    line(62, 95, 195, 4);
    line(63, 95, 195, 4);
    step(1, 0, 0, 0);
    for (int y = 48; y <= 51; y++) line(y, 95, 195, 5);

    // Randomized frames: random ROM contents with key colours, random origin,
    // occasional raster jumps, and frame_start sometimes sharing a pixel cycle.
    for (int f = 0; f < 6; f++) begin
      int y, oy, ox, x0, x1;
      idle(4);
      for (int i = 0; i < 8192; i++) begin
        logic [31:0] r;
        r = $urandom;
        rom[i] = ($urandom_range(0, 5) == 0) ? 16'h0000 : r[15:0];
      end
      ox = int'($urandom_range(0, 639));
      oy = int'($urandom_range(0, 60));
      set_org($urandom_range(0, 4) != 0, ox, oy);
      y  = oy - int'($urandom_range(0, 3));
      if (y < 0) y = 0;
      x0 = (ox > 8) ? ox - 8 : 0;
      x1 = (ox + SW + 8 > 639) ? 639 : ox + SW + 8;
      if ($urandom_range(0, 1) == 1) step(1, 0, 0, 0);
      else                           step(1, 1, x0, y);
      for (int n = 0; n < 110 && y <= oy + SH + 2; n++) begin
        line(y, x0, x1, 4);
        if ($urandom_range(0, 39) == 0) y = y + int'($urandom_range(0, 6)) - 3;
        else                            y = y + 1;
        if (y < 0) y = 0;
      end
    end

    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_rom_reader.md
# sprite_rom_reader

Read-side fetch engine for the pre-initialised single-port sprite ROMs (16-bit RGB565, 90×90 = 8100 words, synchronous read, no output register). It consumes the raster pixel stream from the display timing generator, decides whether each pixel falls inside a sprite placed at a per-frame origin, and drives the ROM address. It then realigns the returned ROM word with that pixel and emits a colour plus hit flag to the layer mixer, treating a key colour as transparent.

## Interface
Parameters:
- SPR_W, 90: sprite width in pixels
- SPR_H, 90: sprite height in pixels
- ADDR_W, 13: ROM address width; must satisfy 2^ADDR_W ≥ SPR_W*SPR_H
- DATA_W, 16: ROM word / pixel width
- COORD_W, 11: screen coordinate width
- KEY_COLOR, 16'h0000: transparent colour

Ports:
- clk  in  1  system clock (same clock as ROM clka)
- rst_n  in  1  reset, asynchronous assert, active-low
- enable  in  1  sprite visible; sampled at frame_start only
- frame_start  in  1  one-cycle pulse before first pixel of a frame
- org_x, org_y  in  COORD_W  sprite top-left; latched at frame_start
- pix_valid  in  1  pixel coordinate valid this cycle
- pix_x, pix_y  in  COORD_W  current raster coordinate
- rom_addr  out  ADDR_W  to ROM addra
- rom_data  in  DATA_W  from ROM doa
- out_valid  out  1  aligned output pixel valid
- out_hit  out  1  opaque sprite pixel at this position
- out_rgb  out  DATA_W  rom_data when out_hit, else 0
- seq_err  out  1  sticky per frame: non-raster y sequence seen inside sprite rows

## Operation
- Clock and reset are decided: one clock, asynchronous active-low reset rst_n.
- frame_start latches org_x/org_y/enable into org regs, clears row_base, cur_y and seq_err. The FSM goes to WAIT if enable is set, else IDLE. frame_start has priority over a same-cycle pixel; that pixel is treated as belonging to the new frame.
- FSM states:
  - IDLE: no hits.
  - WAIT: before the sprite rows.
  - DRAW: inside the sprite rows.
  - DONE: after the sprite rows until the next frame_start.
- New line: detected on a valid pixel with pix_y ≠ cur_y; cur_y is then updated.
- WAIT → DRAW on a new line with pix_y == org_y; row_base ← 0.
- In DRAW, on a new line:
  - pix_y == cur_y+1 and pix_y − org_y < SPR_H: row_base += SPR_W.
  - pix_y − org_y == SPR_H: go to DONE.
  - Any other value: go to DONE and set seq_err.
- Column hit: org_x ≤ pix_x < org_x+SPR_W. Compute with COORD_W+1-bit arithmetic so that org_x+SPR_W beyond the screen does not wrap.
- Address: rom_addr = row_base + (pix_x − org_x), computed at ADDR_W bits.
- Non-hit pixels: rom_addr holds its last value, which avoids needless ROM toggling.
- Transparency: out_hit = in_sprite_d2 && rom_data ≠ KEY_COLOR.
- Pipeline valid bits follow pix_valid regardless of FSM state, so pixels outside the sprite still emit out_valid=1 with out_hit=0.

## Timing
- Stage 0 (cycle N): pix_* sampled; hit and address computed.
- Stage 1 (N+1): rom_addr register valid; the ROM samples it at the end of N+1.
- Stage 2 (N+2): rom_data valid; in_sprite and valid are delayed to match.
- Stage 3 (N+3): out_valid, out_hit and out_rgb registered outputs.
- Fixed latency is 3 cycles from pix_valid to out_valid. There are no bubbles and no backpressure; one pixel per cycle is sustained.
- Reset values: rom_addr=0, out_valid=0, out_hit=0, out_rgb=0, seq_err=0, FSM=IDLE. All pipeline valid bits are cleared.
- Reset asserted mid-DRAW: outputs go to reset values immediately, without waiting for a clock edge. After release, no hits occur until the next frame_start.
- org_x/org_y/enable changes mid-frame have no effect until the next frame_start.
- Sprite partly off-screen (right or bottom): the clipped pixels are simply never requested. The row advance still occurs on each new line, so row_base stays correct.

## Structure
- Shared package sprite_pkg holds:
  - RGB565 pixel type
  - SPR_W/SPR_H defaults
  - KEY_COLOR
  - FSM state enum (IDLE, WAIT, DRAW, DONE)
- No sub-modules. The ROM is instantiated by the parent and connected through rom_addr/rom_data, with its rsta tied low.

## Test plan
- **Reset/idle:** assert rst_n=0 mid-stream → all outputs 0 at once. frame_start with enable=0, then a full raster → out_valid follows pix_valid delayed 3 cycles; out_hit always 0.
- **Address mapping:** org=(100,50), behavioural ROM data = address.
  - (100,50) → rom_addr 0; out_rgb=0 at N+3 with out_hit=0 (key colour).
  - (101,50) → rom_addr 1, out_rgb 16'h0001, out_hit=1.
  - (189,50) → rom_addr 89, out_hit=1.
  - (190,50) and (99,50) → out_hit=0.
- **Row advance and end:** same setup.
  - (100,51) → rom_addr 90.
  - (189,139) → rom_addr 8099.
  - First pixel of y=140 → FSM DONE, out_hit=0 for the rest of the frame.
- **Transparency:** ROM word at address 5 = 16'h0000 → pixel (105,50) gives out_valid=1, out_hit=0, out_rgb=0.
- **Origin latch and edge clip:** change org_x to 0 mid-frame → hits stay at x=100..189 until the next frame_start. Then org=(600,0) on a 640-wide raster → hits only at x=600..639, and row 1 begins at rom_addr 90.
- **Sequence error:** in DRAW at y=60, jump to y=62 → seq_err=1 and no further hits. The next frame_start clears seq_err.
